dec_bit_packer: RTL and testbench

Write-side master for the decoder's word memory. Accepts a serial stream of decoded bits over a valid/ready handshake, packs them LSB-first into MEM_WIDTH-bit words, and writes each completed word to the memory's wen/addr/wdata port at consecutive addresses from a programmable base. Sits between the SC decoder's bit output and the decoded-word memory. Signals completion with a one-cycle done pulse and a word count.

---
 rtl/dec_bit_packer.sv | 172 +++++++++++++++++
 tb/tb_dec_bit_packer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_bit_packer.sv
// Serial-to-word packer: collects decoded bits LSB-first into MEM_WIDTH-bit words
// and writes them to consecutive memory addresses from a programmable base.
module dec_bit_packer #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_DEPTH = 64,
  parameter int MEM_ADDRW = $clog2(MEM_DEPTH),
  parameter int LEN_W     = $clog2(MEM_WIDTH*MEM_DEPTH)+1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [MEM_ADDRW-1:0] i_base_addr,
  input  logic [LEN_W-1:0]     i_nbits,
  input  logic                 i_bit_valid,
  input  logic                 i_bit,
  output logic                 o_bit_ready,
  output logic                 o_mem_wen,
  output logic [MEM_ADDRW-1:0] o_mem_addr,
  output logic [MEM_WIDTH-1:0] o_mem_wdata,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [MEM_ADDRW:0]   o_nwords
);

  localparam int PW = $clog2(MEM_WIDTH);
  localparam logic [LEN_W-1:0] MAX_BITS = LEN_W'(MEM_WIDTH*MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_LAST    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [LEN_W-1:0]      r_nbits;
  logic [LEN_W-1:0]      r_cnt;
  logic [MEM_WIDTH-1:0]  r_pack;
  logic [MEM_ADDRW-1:0]  r_addr;
  logic                  r_ready;
  logic                  r_wen;
  logic [MEM_ADDRW-1:0]  r_mem_addr;
  logic [MEM_WIDTH-1:0]  r_wdata;
  logic                  r_busy;
  logic                  r_done;
  logic [MEM_ADDRW:0]    r_nwords;

  logic                  w_accept;
  logic [PW-1:0]         w_pos;
  logic [MEM_WIDTH-1:0]  w_word;
  logic                  w_last_bit;
  logic                  w_full;
  logic [LEN_W-1:0]      w_nbits_clamped;
  logic [MEM_ADDRW:0]    w_ceil;

  // Datapath decode for the bit currently offered
  always_comb begin
    w_accept        = r_ready & i_bit_valid;
    w_pos           = r_cnt[PW-1:0];
    w_word          = r_pack | (MEM_WIDTH'(i_bit) << w_pos);
    w_last_bit      = ((r_cnt + LEN_W'(1)) == r_nbits);
    w_full          = (w_pos == {PW{1'b1}});
    w_nbits_clamped = (i_nbits > MAX_BITS) ? MAX_BITS : i_nbits;
    w_ceil          = (MEM_ADDRW+1)'((r_nbits + LEN_W'(MEM_WIDTH-1)) >> PW);
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_nbits == LEN_W'(0)) begin
            w_next = S_DONE;
          end else begin
            w_next = S_COLLECT;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (w_accept && w_last_bit) begin
          w_next = S_LAST;
        end else begin
          w_next = S_COLLECT;
        end
      end
      S_LAST:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Packing, addressing and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_nbits    <= '0;
      r_cnt      <= '0;
      r_pack     <= '0;
      r_addr     <= '0;
      r_ready    <= 1'b0;
      r_wen      <= 1'b0;
      r_mem_addr <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_nwords   <= '0;
    end else begin
      r_wen   <= 1'b0;
      r_ready <= (w_next == S_COLLECT);
      r_busy  <= (w_next == S_COLLECT) || (w_next == S_LAST);
      r_done  <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr  <= i_base_addr;
            r_nbits <= w_nbits_clamped;
            r_cnt   <= '0;
            r_pack  <= '0;
            if (i_nbits == LEN_W'(0)) begin
              r_nwords <= '0;
            end
          end
        end
        S_COLLECT: begin
          if (w_accept) begin
            r_cnt <= r_cnt + LEN_W'(1);
            // Hand the word off and clear the packer so the next bit starts clean
            if (w_full || w_last_bit) begin
              r_wen      <= 1'b1;
              r_mem_addr <= r_addr;
              r_wdata    <= w_word;
              r_addr     <= r_addr + MEM_ADDRW'(1);
              r_pack     <= '0;
            end else begin
              r_pack <= w_word;
            end
          end
        end
        S_LAST: begin
          r_nwords <= w_ceil;
        end
        S_DONE: begin
          r_pack <= '0;
        end
        default: begin
          r_pack <= '0;
        end
      endcase
    end
  end

  assign o_bit_ready = r_ready;
  assign o_mem_wen   = r_wen;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_wdata;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_nwords    = r_nwords;

endmodule

// File: tb/tb_dec_bit_packer.sv
// Directed self-checking bench for dec_bit_packer: packet runs with hand-computed
// write sequences, done timing, reset mid-packet and the empty packet.
module tb_dec_bit_packer;

  localparam int MEM_WIDTH = 32;
  localparam int MEM_DEPTH = 64;
  localparam int MEM_ADDRW = 6;
  localparam int LEN_W     = 12;

  logic                 i_clk;
  logic                 i_rst_n;
  logic                 i_start;
  logic [MEM_ADDRW-1:0] i_base_addr;
  logic [LEN_W-1:0]     i_nbits;
  logic                 i_bit_valid;
  logic                 i_bit;
  logic                 o_bit_ready;
  logic                 o_mem_wen;
  logic [MEM_ADDRW-1:0] o_mem_addr;
  logic [MEM_WIDTH-1:0] o_mem_wdata;
  logic                 o_busy;
  logic                 o_done;
  logic [MEM_ADDRW:0]   o_nwords;

  int n_tests;
  int n_fail;
  int done_cnt;
  logic [MEM_ADDRW-1:0] q_addr[$];
  logic [MEM_WIDTH-1:0] q_data[$];

  dec_bit_packer #(
    .MEM_WIDTH(MEM_WIDTH),
    .MEM_DEPTH(MEM_DEPTH),
    .MEM_ADDRW(MEM_ADDRW),
    .LEN_W(LEN_W)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .i_base_addr(i_base_addr),
    .i_nbits(i_nbits),
    .i_bit_valid(i_bit_valid),
    .i_bit(i_bit),
    .o_bit_ready(o_bit_ready),
    .o_mem_wen(o_mem_wen),
    .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_nwords(o_nwords)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Write/done monitor, sampled mid-cycle
  always @(negedge i_clk) begin
    if (o_mem_wen === 1'b1) begin
      q_addr.push_back(o_mem_addr);
      q_data.push_back(o_mem_wdata);
    end
    if (o_done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_write(input int idx, input logic [MEM_ADDRW-1:0] addr,
                           input logic [MEM_WIDTH-1:0] data);
    if (idx < q_addr.size()) begin
      check($sformatf("wr%0d_addr", idx), 64'(q_addr[idx]), 64'(addr));
      check($sformatf("wr%0d_data", idx), 64'(q_data[idx]), 64'(data));
    end else begin
      check($sformatf("wr%0d_missing", idx), 64'(q_addr.size()), 64'(idx + 1));
    end
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    done_cnt = 0;
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the edge at T+3
  task automatic run_packet(input logic [MEM_ADDRW-1:0] base, input int nbits,
                            input logic [127:0] data, input int gap,
                            input bit pulse_start, input int exp_nwords);
    i_start     = 1'b1;
    i_base_addr = base;
    i_nbits     = LEN_W'(nbits);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check("busy_S1", 64'(o_busy), 64'd1);
    check("ready_S1", 64'(o_bit_ready), 64'd1);
    for (int k = 0; k < nbits; k++) begin
      for (int g = 0; g < gap; g++) begin
        i_bit_valid = 1'b0;
        if (pulse_start && k == 5 && g == 0) begin
          i_start     = 1'b1;
          i_nbits     = 12'd0;
          i_base_addr = 6'd40;
        end
        @(posedge i_clk); #1;
        i_start = 1'b0;
      end
      i_bit_valid = 1'b1;
      i_bit       = data[k];
      @(posedge i_clk); #1;
    end
    i_bit_valid = 1'b0;
    check("wen_T1", 64'(o_mem_wen), 64'd1);
    check("ready_T1", 64'(o_bit_ready), 64'd0);
    check("done_T1", 64'(o_done), 64'd0);
    @(posedge i_clk); #1;
    check("done_T2", 64'(o_done), 64'd1);
    check("busy_T2", 64'(o_busy), 64'd0);
    check("wen_T2", 64'(o_mem_wen), 64'd0);
    check("nwords", 64'(o_nwords), 64'(exp_nwords));
    @(posedge i_clk); #1;
    check("done_T3", 64'(o_done), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(o_bit_ready), 64'd0);
    check({tag, "_wen"},   64'(o_mem_wen),   64'd0);
    check({tag, "_addr"},  64'(o_mem_addr),  64'd0);
    check({tag, "_wdata"}, 64'(o_mem_wdata), 64'd0);
    check({tag, "_busy"},  64'(o_busy),      64'd0);
    check({tag, "_done"},  64'(o_done),      64'd0);
    check({tag, "_nw"},    64'(o_nwords),    64'd0);
  endtask

  initial begin
    logic [127:0] d40;
    n_tests = 0;
    n_fail  = 0;
    done_cnt = 0;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_base_addr = '0;
    i_nbits = '0;
    i_bit_valid = 1'b0;
    i_bit = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_all_zero("rst");
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check_all_zero("rst_rel");

    // 32 alternating bits
    clear_log();
    run_packet(6'd0, 32, {96'd0, 32'h55555555}, 0, 1'b0, 1);
    check("t1_nwr", 64'(q_addr.size()), 64'd1);
    exp_write(0, 6'd0, 32'h55555555);
    check("t1_hold_addr", 64'(o_mem_addr), 64'd0);
    check("t1_hold_data", 64'(o_mem_wdata), 64'h55555555);

    // 70 ones from base 5, back-to-back with the previous packet
    clear_log();
    run_packet(6'd5, 70, {128{1'b1}}, 0, 1'b0, 3);
    check("t2_nwr", 64'(q_addr.size()), 64'd3);
    exp_write(0, 6'd5, 32'hFFFFFFFF);
    exp_write(1, 6'd6, 32'hFFFFFFFF);
    exp_write(2, 6'd7, 32'h0000003F);

    // Address wrap 63 -> 0
    clear_log();
    run_packet(6'd63, 64, {64'd0, 32'h12345678, 32'hDEADBEEF}, 0, 1'b0, 2);
    check("t3_nwr", 64'(q_addr.size()), 64'd2);
    exp_write(0, 6'd63, 32'hDEADBEEF);
    exp_write(1, 6'd0, 32'h12345678);
    check("t3_done_cnt", 64'(done_cnt), 64'd1);

    // 40 bits at full rate, then the same bits every third cycle with a stray start
    d40 = {88'd0, 8'hA5, 32'hCAFEF00D};
    clear_log();
    run_packet(6'd10, 40, d40, 0, 1'b0, 2);
    check("t4a_nwr", 64'(q_addr.size()), 64'd2);
    exp_write(0, 6'd10, 32'hCAFEF00D);
    exp_write(1, 6'd11, 32'h000000A5);
    clear_log();
    run_packet(6'd10, 40, d40, 2, 1'b1, 2);
    check("t4b_nwr", 64'(q_addr.size()), 64'd2);
    exp_write(0, 6'd10, 32'hCAFEF00D);
    exp_write(1, 6'd11, 32'h000000A5);
    check("t4b_done_cnt", 64'(done_cnt), 64'd1);

    // Reset after 10 accepted bits
    clear_log();
    i_start = 1'b1;
    i_base_addr = 6'd20;
    i_nbits = 12'd32;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      i_bit_valid = 1'b1;
      i_bit = 1'b1;
      @(posedge i_clk); #1;
    end
    i_bit_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("t5_nwr", 64'(q_addr.size()), 64'd0);
    check("t5_done_cnt", 64'(done_cnt), 64'd0);
    run_packet(6'd3, 32, {96'd0, 32'h0F0F1234}, 0, 1'b0, 1);
    check("t5b_nwr", 64'(q_addr.size()), 64'd1);
    exp_write(0, 6'd3, 32'h0F0F1234);

    // Empty packet
    clear_log();
    i_start = 1'b1;
    i_base_addr = 6'd9;
    i_nbits = 12'd0;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check("t6_done", 64'(o_done), 64'd1);
    check("t6_busy", 64'(o_busy), 64'd0);
    check("t6_ready", 64'(o_bit_ready), 64'd0);
    check("t6_nwords", 64'(o_nwords), 64'd0);
    @(posedge i_clk); #1;
    check("t6_done_off", 64'(o_done), 64'd0);
    repeat (3) @(posedge i_clk);
    #1;
    check("t6_nwr", 64'(q_addr.size()), 64'd0);
    check("t6_done_cnt", 64'(done_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
